// File: rtl/hex_lexer_fifo.sv
// Buffered hex-token lexer: input char FIFO -> IDLE/NUM/BAD lexer -> output byte FIFO.
// Define HEX_LEXER_LOWERCASE_EN to emit hex digits lowercase instead of uppercase.
module hex_lexer_fifo #(
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_back,
    input  logic       pop_front,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full,
    output logic       error
);

    localparam int IAW = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
    localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_Q  = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NUM,
        ST_BAD
    } state_t;

    typedef enum logic [1:0] {
        CL_DIGIT,
        CL_SEP,
        CL_OTHER
    } cls_t;

    function automatic cls_t classify(input logic [7:0] c);
        if ((c >= 8'h30 && c <= 8'h39) ||
            (c >= 8'h41 && c <= 8'h46) ||
            (c >= 8'h61 && c <= 8'h66))
            return CL_DIGIT;
        if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == 8'h2C)
            return CL_SEP;
        return CL_OTHER;
    endfunction

    // Only called on digits; letters are folded to the configured case.
    function automatic logic [7:0] fold_digit(input logic [7:0] c);
`ifdef HEX_LEXER_LOWERCASE_EN
        if (c >= 8'h41 && c <= 8'h46)
            return c | 8'h20;
`else
        if (c >= 8'h61 && c <= 8'h66)
            return c & 8'hDF;
`endif
        return c;
    endfunction

    logic [7:0]     in_mem [IN_DEPTH];
    logic [IAW-1:0] in_wr_ptr;
    logic [IAW-1:0] in_rd_ptr;
    logic [IAW:0]   in_cnt;
    logic           in_empty;
    logic           push_ok;

    logic [7:0]     out_mem [OUT_DEPTH];
    logic [OAW-1:0] out_wr_ptr;
    logic [OAW-1:0] out_rd_ptr;
    logic [OAW:0]   out_cnt;
    logic           out_full;
    logic           out_wr;
    logic [7:0]     out_wr_byte;
    logic           pop_ok;

    state_t         state;
    state_t         state_nxt;
    cls_t           cls_p0;
    logic [7:0]     ch_p0;
    logic           lex_step;
    logic           emit0_vld;
    logic [7:0]     emit0;
    logic           emit1_vld;
    logic [7:0]     emit1;

    logic           pend_vld_p1;
    logic [7:0]     pend_byte_p1;
    logic           pend_drain;

    assign full     = (in_cnt  == (IAW+1)'(IN_DEPTH));
    assign in_empty = (in_cnt  == '0);
    assign out_full = (out_cnt == (OAW+1)'(OUT_DEPTH));
    assign empty    = (out_cnt == '0);

    assign push_ok = push_back && !full;
    assign pop_ok  = pop_front && !empty;

    // A pending second byte blocks the lexer until it has been written out.
    assign lex_step   = !pend_vld_p1 && !in_empty && !out_full;
    assign pend_drain =  pend_vld_p1 && !out_full;

    assign ch_p0  = in_mem[in_rd_ptr];
    assign cls_p0 = classify(ch_p0);

    // ---- stage p0: classify head character, decide emissions ----
    always_comb begin
        state_nxt = state;
        emit0_vld = 1'b0;
        emit0     = 8'h00;
        emit1_vld = 1'b0;
        emit1     = 8'h00;
        if (lex_step) begin
            case (state)
                ST_IDLE: begin
                    if (cls_p0 == CL_DIGIT) begin
                        emit0_vld = 1'b1;
                        emit0     = fold_digit(ch_p0);
                        state_nxt = ST_NUM;
                    end else if (cls_p0 == CL_OTHER) begin
                        emit0_vld = 1'b1;
                        emit0     = ASCII_Q;
                        state_nxt = ST_BAD;
                    end
                end
                ST_NUM: begin
                    emit0_vld = 1'b1;
                    if (cls_p0 == CL_DIGIT) begin
                        emit0 = fold_digit(ch_p0);
                    end else if (cls_p0 == CL_SEP) begin
                        emit0     = ASCII_LF;
                        state_nxt = ST_IDLE;
                    end else begin
                        emit0     = ASCII_LF;
                        emit1_vld = 1'b1;
                        emit1     = ASCII_Q;
                        state_nxt = ST_BAD;
                    end
                end
                ST_BAD: begin
                    if (cls_p0 == CL_SEP) begin
                        emit0_vld = 1'b1;
                        emit0     = ASCII_LF;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ---- stage p1: pending byte and output FIFO write ----
    assign out_wr      = (lex_step && emit0_vld) || pend_drain;
    assign out_wr_byte = pend_drain ? pend_byte_p1 : emit0;

    always_ff @(posedge clk) begin
        if (rst)
            pend_vld_p1 <= 1'b0;
        else if (lex_step && emit1_vld)
            pend_vld_p1 <= 1'b1;
        else if (pend_drain)
            pend_vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (lex_step && emit1_vld)
            pend_byte_p1 <= emit1;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            in_mem[in_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_cnt    <= '0;
        end else begin
            if (push_ok)
                in_wr_ptr <= in_wr_ptr + IAW'(1);
            if (lex_step)
                in_rd_ptr <= in_rd_ptr + IAW'(1);
            case ({push_ok, lex_step})
                2'b10:   in_cnt <= in_cnt + (IAW+1)'(1);
                2'b01:   in_cnt <= in_cnt - (IAW+1)'(1);
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (out_wr)
            out_mem[out_wr_ptr] <= out_wr_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_cnt    <= '0;
        end else begin
            if (out_wr)
                out_wr_ptr <= out_wr_ptr + OAW'(1);
            if (pop_ok)
                out_rd_ptr <= out_rd_ptr + OAW'(1);
            case ({out_wr, pop_ok})
                2'b10:   out_cnt <= out_cnt + (OAW+1)'(1);
                2'b01:   out_cnt <= out_cnt - (OAW+1)'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // ---- stage p2: registered output byte and sticky protocol error ----
    always_ff @(posedge clk) begin
        if (rst)
            data_out <= 8'h00;
        else if (pop_ok)
            data_out <= out_mem[out_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            error <= 1'b0;
        else if ((push_back && full) || (pop_front && empty))
            error <= 1'b1;
    end

endmodule

// File: tb/tb_hex_lexer_fifo.sv
// Self-checking bench for hex_lexer_fifo: a reference lexer model feeds an expected-byte
// queue that is compared against every byte popped from the DUT.
module tb_hex_lexer_fifo;

    localparam int IN_DEPTH  = 16;
    localparam int OUT_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_back = 1'b0;
    logic       pop_front = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       error;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         m_st = 0;
    logic [7:0] last_out = 8'h00;
    bit         pushing = 0;

    hex_lexer_fifo #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst(rst), .push_back(push_back), .pop_front(pop_front),
        .data_in(data_in), .data_out(data_out), .empty(empty), .full(full), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef HEX_LEXER_LOWERCASE_EN
        if (c >= 8'h41 && c <= 8'h46) return c + 8'h20;
`else
        if (c >= 8'h61 && c <= 8'h66) return c - 8'h20;
`endif
        return c;
    endfunction

    function automatic void model_char(input logic [7:0] c);
        bit dig;
        bit sep;
        dig = (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
        sep = (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D) || (c == 8'h2C);
        case (m_st)
            0: if (dig) begin exp_q.push_back(fold(c)); m_st = 1; end
               else if (!sep) begin exp_q.push_back(8'h3F); m_st = 2; end
            1: if (dig) exp_q.push_back(fold(c));
               else if (sep) begin exp_q.push_back(8'h0A); m_st = 0; end
               else begin exp_q.push_back(8'h0A); exp_q.push_back(8'h3F); m_st = 2; end
            default: if (sep) begin exp_q.push_back(8'h0A); m_st = 0; end
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; push_back = 1; pop_front = 1; data_in = 8'h31;
        @(negedge clk);
        @(negedge clk);
        rst = 0; push_back = 0; pop_front = 0;
        exp_q.delete();
        m_st = 0;
        last_out = 8'h00;
    endtask

    task automatic push_char(input logic [7:0] c);
        int w = 0;
        @(negedge clk);
        while (full && w < 400) begin @(negedge clk); w++; end
        if (full) begin
            errors++; checks++;
            $display("FAIL push_wait: full stuck at %0b, required 0", full);
        end
        data_in = c; push_back = 1;
        model_char(c);
        @(posedge clk); #1;
        push_back = 0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push_char(s[i]);
    endtask

    task automatic drain(input string name, input int start_delay, input int gap, input int budget);
        int cyc = 0;
        int hold = start_delay;
        bit pend = 0;
        logic [7:0] e;
        pop_front = 0;
        while ((pushing || exp_q.size() > 0 || pend) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            pop_front = 0;
            if (pend) begin
                e = exp_q.pop_front();
                checks++;
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL %s_byte: data_out=%02h required=%02h", name, data_out, e);
                end
                last_out = e;
                pend = 0;
            end
            if (hold > 0) hold--;
            else if (exp_q.size() > 0 && !empty) begin
                pop_front = 1; pend = 1; hold = gap;
            end
        end
        pop_front = 0;
        if (pend || exp_q.size() > 0) begin
            errors++; checks++;
            $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL %s_empty: empty=%0b required=1", name, empty);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data: data_out=%02h required=00", data_out); end
        if (empty !== 1'b1)     begin errors++; $display("FAIL rst_empty: empty=%0b required=1", empty); end
        if (full !== 1'b0)      begin errors++; $display("FAIL rst_full: full=%0b required=0", full); end
        if (error !== 1'b0)     begin errors++; $display("FAIL rst_error: error=%0b required=0", error); end
        repeat (3) @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_push_ignored: empty=%0b required=1", empty); end
    endtask

    task automatic test_basic();
        push_str("1a F\n");
        drain("basic", 0, 0, 500);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL basic_error: error=%0b required=0", error); end
    endtask

    task automatic test_bad_token();
        push_str("1g2 3 ");
        drain("bad", 0, 0, 500);
    endtask

    task automatic test_latency();
        logic [7:0] e;
        @(negedge clk);
        data_in = 8'h41; push_back = 1;
        model_char(8'h41);
        @(negedge clk);
        push_back = 0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL lat_k: empty=%0b required=1", empty); end
        @(negedge clk);
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL lat_k1: empty=%0b required=0", empty); end
        pop_front = 1;
        @(negedge clk);
        pop_front = 0;
        e = exp_q.pop_front();
        checks += 2;
        if (data_out !== e) begin errors++; $display("FAIL lat_pop: data_out=%02h required=%02h", data_out, e); end
        if (empty !== 1'b1) begin errors++; $display("FAIL lat_empty: empty=%0b required=1", empty); end
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== e) begin errors++; $display("FAIL lat_hold: data_out=%02h required=%02h", data_out, e); end
        push_str(" ");
        drain("lat_tail", 0, 0, 200);
    endtask

    task automatic test_back_to_back();
        pushing = 1;
        fork
            begin push_str("dead BEEF,c0fFee\n"); pushing = 0; end
            drain("b2b", 0, 0, 2000);
        join
    endtask

    task automatic test_backpressure();
        pushing = 1;
        fork
            begin push_str("123456789012345g9 7e,q1 \tFF\015-a b\n12345678 ,x0\n"); pushing = 0; end
            drain("bp", 60, 2, 5000);
        join
    endtask

    task automatic test_pop_empty();
        logic [7:0] prev;
        prev = last_out;
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL pe_pre_error: error=%0b required=0", error); end
        @(negedge clk);
        pop_front = 1;
        @(negedge clk);
        pop_front = 0;
        checks += 2;
        if (data_out !== prev) begin errors++; $display("FAIL pe_data: data_out=%02h required=%02h", data_out, prev); end
        if (error !== 1'b1)    begin errors++; $display("FAIL pe_error: error=%0b required=1", error); end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL pe_sticky: error=%0b required=1", error); end
        do_reset();
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL pe_clear: error=%0b required=0", error); end
    endtask

    task automatic test_full_error();
        int n = 0;
        @(negedge clk);
        while (!full && n < 64) begin
            data_in = 8'h30 + 8'(n % 10);
            push_back = 1;
            model_char(data_in);
            n++;
            @(negedge clk);
        end
        push_back = 0;
        checks += 3;
        if (n != IN_DEPTH + OUT_DEPTH) begin errors++; $display("FAIL fill_count: accepted=%0d required=%0d", n, IN_DEPTH + OUT_DEPTH); end
        if (full !== 1'b1)  begin errors++; $display("FAIL fill_full: full=%0b required=1", full); end
        if (error !== 1'b0) begin errors++; $display("FAIL fill_error: error=%0b required=0", error); end
        data_in = 8'h5A; push_back = 1;
        @(negedge clk);
        push_back = 0;
        checks += 2;
        if (error !== 1'b1) begin errors++; $display("FAIL ovf_error: error=%0b required=1", error); end
        if (full !== 1'b1)  begin errors++; $display("FAIL ovf_full: full=%0b required=1", full); end
        drain("ovf", 0, 0, 1000);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL ovf_sticky: error=%0b required=1", error); end
        push_str("77 q");
        do_reset();
        checks += 4;
        if (empty !== 1'b1)     begin errors++; $display("FAIL mid_rst_empty: empty=%0b required=1", empty); end
        if (full !== 1'b0)      begin errors++; $display("FAIL mid_rst_full: full=%0b required=0", full); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_data: data_out=%02h required=00", data_out); end
        if (error !== 1'b0)     begin errors++; $display("FAIL mid_rst_error: error=%0b required=0", error); end
        push_str("5,");
        drain("post_rst", 0, 0, 300);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_token();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_pop_empty();
        test_full_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
